shot_encoder: RTL and testbench
===============================

SHOT_ENCODER -- requirements
Module: shot_encoder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
  T_MARK, 17500, cycles of forced-active mark at the start of each bit cell
  T_DATA, 35000, cycles the bit value is held after the mark
  T_GUARD, 17500, cycles of forced-idle guard ending each bit cell
  CARRIER_DIV, 0, half-period of IR carrier in cycles; 0 means no carrier
REQ-003 Ports SHALL be, one per line:
  PCLK  in  1  clock
  PRESET  in  1  synchronous active-high reset
  PSEL, PENABLE, PWRITE  in  1 each  APB control
  PADDR  in  8  APB address
  PWDATA  in  32  APB write data
  PRDATA  out  32  APB read data (combinational)
  PREADY  out  1  tied 1
  PSLVERR  out  1  tied 0
  ir_led  out  1  IR emitter drive, active-high, idle 0
  fire_int  out  1  one-cycle pulse at end of transmitted frame

Function
REQ-004 An APB write SHALL occur when PSEL && PENABLE && PWRITE are all 1; PADDR 0x00 = CTRL, 0x04 = ID, 0x08 = COOLDOWN.
REQ-005 An ID write SHALL store PWDATA[0] as own_id.
REQ-006 A COOLDOWN write SHALL store PWDATA[23:0] as cooldown_len.
REQ-007 A CTRL write with PWDATA[0]=1 in IDLE SHALL latch frame = {~own_id, PWDATA[2:1]} and enter MARK the next cycle.
REQ-008 A CTRL fire write outside IDLE SHALL be ignored and SHALL set sticky overrun; a CTRL write with PWDATA[3]=1 SHALL clear overrun.
REQ-009 Frame bits SHALL be sent MSB first, frame[2] down to frame[0], one bit cell each.
REQ-010 States: IDLE -> MARK (T_MARK cycles) -> DATA (T_DATA) -> GUARD (T_GUARD) -> MARK for the next bit, or COOLDOWN after bit 0 -> IDLE after cooldown_len cycles.
REQ-011 cooldown_len=0 SHALL make COOLDOWN last exactly 1 cycle.
REQ-012 The raw line SHALL be 1 in MARK, frame[bit] in DATA, and 0 in GUARD, COOLDOWN and IDLE.
REQ-013 ir_led SHALL be the raw line registered, one cycle of latency.
REQ-014 If CARRIER_DIV>0, ir_led SHALL be the raw line AND a free-running square wave toggling every CARRIER_DIV cycles.
REQ-015 fire_int SHALL be 1 for exactly the first cycle of COOLDOWN.
REQ-016 PRDATA SHALL be {26'b0, overrun, busy, frame[2:0], own_id}, where busy = (state != IDLE).
REQ-017 All cycle counters SHALL be 24 bits and SHALL reset to 0 on each state change.
REQ-018 Writes to undefined addresses SHALL have no effect.

Reset
REQ-019 PRESET SHALL force state=IDLE, ir_led=0, fire_int=0, overrun=0, counters=0, own_id=0, cooldown_len=0, frame=0, carrier phase=0.
REQ-020 PRESET mid-frame SHALL abort transmission with ir_led=0 on the next cycle and no fire_int.
REQ-021 PRESET SHALL take priority over a simultaneous APB write.

Structure
REQ-022 A shared package SHALL hold the state enum, the APB register offsets and the default timing constants.
REQ-023 Bit-cell timing SHALL live in one sub-module, ir_cell_timer: 24-bit down-counter with load and a done flag.

Verification (T_MARK=2, T_DATA=4, T_GUARD=2, CARRIER_DIV=0, unless stated)
REQ-024 ID=1, CTRL=0x5 -> frame=3'b010; ir_led = 11000000 11111100 11000000, then fire_int pulse, then IDLE.
REQ-025 COOLDOWN=3, fire -> busy=1 for 24+3 cycles after the CTRL write; a fire during COOLDOWN sets overrun=1 and ir_led stays 0.
REQ-026 PRESET asserted during bit 1 DATA -> next cycle ir_led=0, busy=0; no fire_int.
REQ-027 CARRIER_DIV=1, frame 3'b111 -> ir_led toggles every cycle during MARK and DATA, and is 0 in GUARD.
REQ-028 Loopback into the hit receiver with defaults, receiver id different from sender -> receiver result = frame and hit_int asserted; same id -> no hit_int.

Source files
------------

// File: rtl/shot_encoder_pkg.sv
// Shared types and constants for the IR shot encoder: FSM states, APB register
// offsets and default bit-cell timing.
package shot_encoder_pkg;

    localparam int unsigned CNT_W = 24;

    localparam int unsigned DEF_T_MARK      = 17500;
    localparam int unsigned DEF_T_DATA      = 35000;
    localparam int unsigned DEF_T_GUARD     = 17500;
    localparam int unsigned DEF_CARRIER_DIV = 0;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_ID       = 8'h04;
    localparam logic [7:0] ADDR_COOLDOWN = 8'h08;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_DATA,
        ST_GUARD,
        ST_COOLDOWN
    } state_e;

    // A down-counter that reaches zero after n cycles is loaded with n-1.
    function automatic logic [CNT_W-1:0] cycles_to_load(input int unsigned n);
        return (n == 0) ? '0 : CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/shot_encoder_ir_cell_timer.sv
// Bit-cell timer: 24-bit down-counter, loaded on every state change, with a
// done flag while the count sits at zero.
module ir_cell_timer
    import shot_encoder_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/shot_encoder.sv
// IR shot encoder: APB-programmed 3-bit frame sent MSB first as mark/data/guard
// bit cells, followed by a cooldown, with optional carrier modulation.
module shot_encoder
    import shot_encoder_pkg::*;
#(
    parameter int unsigned T_MARK      = DEF_T_MARK,
    parameter int unsigned T_DATA      = DEF_T_DATA,
    parameter int unsigned T_GUARD     = DEF_T_GUARD,
    parameter int unsigned CARRIER_DIV = DEF_CARRIER_DIV
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        ir_led,
    output logic        fire_int
);

    localparam logic [CNT_W-1:0] MARK_LD  = cycles_to_load(T_MARK);
    localparam logic [CNT_W-1:0] DATA_LD  = cycles_to_load(T_DATA);
    localparam logic [CNT_W-1:0] GUARD_LD = cycles_to_load(T_GUARD);
    localparam logic [CNT_W-1:0] CAR_LAST = cycles_to_load(CARRIER_DIV);

    state_e           state_q, state_d;
    logic [2:0]       frame_q, frame_d;
    logic [1:0]       bit_q, bit_d;
    logic             own_id_q;
    logic [CNT_W-1:0] cooldown_len_q;
    logic             overrun_q;
    logic             ir_led_q;
    logic             fire_int_q;
    logic             carrier_q;
    logic [CNT_W-1:0] car_cnt_q;

    logic             apb_wr;
    logic             ctrl_wr;
    logic             fire_req;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             raw;
    logic             unused_pwdata;

    assign apb_wr        = PSEL & PENABLE & PWRITE;
    assign ctrl_wr       = apb_wr && (PADDR == ADDR_CTRL);
    assign fire_req      = ctrl_wr & PWDATA[0];
    assign unused_pwdata = ^PWDATA[31:24];

    ir_cell_timer u_timer (
        .clk_i      (PCLK),
        .rst_i      (PRESET),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        bit_d    = bit_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        raw      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fire_req) begin
                    state_d  = ST_MARK;
                    frame_d  = {~own_id_q, PWDATA[2:1]};
                    bit_d    = 2'd2;
                    tmr_load = 1'b1;
                    tmr_val  = MARK_LD;
                end
            end
            ST_MARK: begin
                raw = 1'b1;
                if (tmr_done) begin
                    state_d  = ST_DATA;
                    tmr_load = 1'b1;
                    tmr_val  = DATA_LD;
                end
            end
            ST_DATA: begin
                raw = frame_q[bit_q];
                if (tmr_done) begin
                    state_d  = ST_GUARD;
                    tmr_load = 1'b1;
                    tmr_val  = GUARD_LD;
                end
            end
            ST_GUARD: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (bit_q == 2'd0) begin
                        // A zero cooldown length still spends one cycle here.
                        state_d = ST_COOLDOWN;
                        tmr_val = (cooldown_len_q == '0) ? '0 : cooldown_len_q - CNT_W'(1);
                    end else begin
                        state_d = ST_MARK;
                        bit_d   = bit_q - 2'd1;
                        tmr_val = MARK_LD;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q        <= ST_IDLE;
            frame_q        <= '0;
            bit_q          <= '0;
            own_id_q       <= 1'b0;
            cooldown_len_q <= '0;
            overrun_q      <= 1'b0;
            ir_led_q       <= 1'b0;
            fire_int_q     <= 1'b0;
            carrier_q      <= 1'b0;
            car_cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_q      <= bit_d;
            ir_led_q   <= (CARRIER_DIV == 0) ? raw : (raw & carrier_q);
            fire_int_q <= (state_d == ST_COOLDOWN) && (state_q != ST_COOLDOWN);
            if (apb_wr && (PADDR == ADDR_ID)) begin
                own_id_q <= PWDATA[0];
            end
            if (apb_wr && (PADDR == ADDR_COOLDOWN)) begin
                cooldown_len_q <= PWDATA[23:0];
            end
            // Clear is applied first so a simultaneous late fire still flags overrun.
            if (ctrl_wr) begin
                if (PWDATA[3]) begin
                    overrun_q <= 1'b0;
                end
                if (PWDATA[0] && (state_q != ST_IDLE)) begin
                    overrun_q <= 1'b1;
                end
            end
            if (car_cnt_q == CAR_LAST) begin
                car_cnt_q <= '0;
                carrier_q <= ~carrier_q;
            end else begin
                car_cnt_q <= car_cnt_q + CNT_W'(1);
            end
        end
    end

    assign PRDATA   = {26'b0, overrun_q, (state_q != ST_IDLE), frame_q, own_id_q};
    assign PREADY   = 1'b1;
    assign PSLVERR  = 1'b0;
    assign ir_led   = ir_led_q;
    assign fire_int = fire_int_q;

endmodule

// File: tb/tb_shot_encoder.sv
// Self-checking bench: a cycle-schedule model of the frame waveform checked
// every cycle against two encoder instances (no carrier, carrier every cycle).
module tb_shot_encoder;

    localparam int unsigned TM   = 2;
    localparam int unsigned TD   = 4;
    localparam int unsigned TG   = 2;
    localparam int unsigned CDIV = 1;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;

    logic [31:0] PRDATA, PRDATA_c;
    logic        PREADY, PREADY_c, PSLVERR, PSLVERR_c;
    logic        ir_led, ir_led_c, fire_int, fire_int_c;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    always #5 PCLK = ~PCLK;

    shot_encoder #(.T_MARK(TM), .T_DATA(TD), .T_GUARD(TG), .CARRIER_DIV(0)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .ir_led(ir_led), .fire_int(fire_int)
    );

    shot_encoder #(.T_MARK(TM), .T_DATA(TD), .T_GUARD(TG), .CARRIER_DIV(CDIV)) dut_c (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA_c), .PREADY(PREADY_c),
        .PSLVERR(PSLVERR_c), .ir_led(ir_led_c), .fire_int(fire_int_c)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: each accepted fire expands into a list of per-cycle raw levels.
    typedef struct packed {
        logic raw;
        logic fire;
    } ent_t;

    ent_t        sched[$];
    logic        m_led = 1'b0, m_led_c = 1'b0, m_fire = 1'b0, m_ovr = 1'b0, m_id = 1'b0;
    logic [2:0]  m_frame = '0;
    logic [23:0] m_cd = '0;
    int unsigned m_n = 0;
    bit          m_valid = 1'b0;

    always @(posedge PCLK) begin : model
        logic r, car;
        bit was_idle;
        int unsigned ncd;
        if (PRESET) begin
            sched.delete();
            m_led = 0; m_led_c = 0; m_fire = 0; m_ovr = 0; m_id = 0;
            m_frame = '0; m_cd = '0; m_n = 0; m_valid = 1'b1;
        end else begin
            r        = (sched.size() > 0) ? sched[0].raw : 1'b0;
            car      = ((m_n / CDIV) % 2) == 1;
            m_n++;
            was_idle = (sched.size() == 0);
            if (!was_idle) void'(sched.pop_front());
            m_led   = r;
            m_led_c = r & car;
            if (PSEL && PENABLE && PWRITE) begin
                case (PADDR)
                    8'h04: m_id = PWDATA[0];
                    8'h08: m_cd = PWDATA[23:0];
                    8'h00: begin
                        if (PWDATA[3]) m_ovr = 1'b0;
                        if (PWDATA[0]) begin
                            if (was_idle) begin
                                m_frame = {~m_id, PWDATA[2:1]};
                                for (int b = 2; b >= 0; b--) begin
                                    for (int i = 0; i < int'(TM); i++) sched.push_back('{1'b1, 1'b0});
                                    for (int i = 0; i < int'(TD); i++) sched.push_back('{m_frame[b], 1'b0});
                                    for (int i = 0; i < int'(TG); i++) sched.push_back('{1'b0, 1'b0});
                                end
                                ncd = (m_cd == 0) ? 1 : int'(m_cd);
                                for (int i = 0; i < int'(ncd); i++) sched.push_back('{1'b0, i == 0});
                            end else begin
                                m_ovr = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            m_fire = (sched.size() > 0) && sched[0].fire;
        end
    end

    always @(negedge PCLK) begin : compare
        logic [31:0] exp_rd;
        if (m_valid && !done) begin
            exp_rd = {26'b0, m_ovr, (sched.size() > 0), m_frame, m_id};
            chk("ir_led", {31'b0, ir_led}, {31'b0, m_led});
            chk("fire_int", {31'b0, fire_int}, {31'b0, m_fire});
            chk("prdata", PRDATA, exp_rd);
            chk("ir_led_carrier", {31'b0, ir_led_c}, {31'b0, m_led_c});
            chk("fire_int_carrier", {31'b0, fire_int_c}, {31'b0, m_fire});
            chk("prdata_carrier", PRDATA_c, exp_rd);
        end
    end

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (PRDATA[4] && cnt < 200) begin
            cnt++;
            @(negedge PCLK);
        end
        chk("idle_timeout", {31'b0, PRDATA[4]}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [23:0] led_v, fire_v;
        logic [7:0]  car_v;
        int          busy_cnt;

        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        chk("reset_prdata", PRDATA, 32'h0);
        chk("reset_ir_led", {31'b0, ir_led}, 32'd0);
        chk("reset_fire", {31'b0, fire_int}, 32'd0);
        chk("pready", {31'b0, PREADY}, 32'd1);
        chk("pslverr", {31'b0, PSLVERR}, 32'd0);

        apb_write(8'h04, 32'h1);
        chk("id_write", PRDATA, 32'h1);
        apb_write(8'h0C, 32'hFFFF_FFFF);
        chk("undef_addr", PRDATA, 32'h1);

        // Frame 3'b010: one 8-cycle cell per bit, then a 1-cycle cooldown.
        apb_write(8'h00, 32'h5);
        led_v = '0; fire_v = '0;
        for (int i = 0; i < 24; i++) begin
            @(negedge PCLK);
            led_v  = {led_v[22:0], ir_led};
            fire_v = {fire_v[22:0], fire_int};
        end
        chk("frame010_led", {8'b0, led_v}, {8'b0, 24'b11000000_11111100_11000000});
        chk("frame010_fire", {8'b0, fire_v}, 32'h1);
        @(negedge PCLK);
        chk("frame010_done", PRDATA, 32'h5);

        apb_write(8'h08, 32'd3);
        apb_write(8'h00, 32'h1);
        busy_cnt = 0;
        while (PRDATA[4] && busy_cnt < 100) begin
            busy_cnt++;
            @(negedge PCLK);
        end
        chk("busy_cycles", busy_cnt, 32'd27);

        // Second fire lands inside the 10-cycle cooldown.
        apb_write(8'h08, 32'd10);
        apb_write(8'h00, 32'h1);
        repeat (23) @(negedge PCLK);
        apb_write(8'h00, 32'h1);
        chk("overrun_set", {31'b0, PRDATA[5]}, 32'd1);
        chk("overrun_busy", {31'b0, PRDATA[4]}, 32'd1);
        wait_idle();
        chk("overrun_sticky", {31'b0, PRDATA[5]}, 32'd1);
        apb_write(8'h00, 32'h8);
        chk("overrun_clear", {31'b0, PRDATA[5]}, 32'd0);

        apb_write(8'h00, 32'h5);
        repeat (10) @(negedge PCLK);
        chk("bit1_data_led", {31'b0, ir_led}, 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("abort_led", {31'b0, ir_led}, 32'd0);
        chk("abort_prdata", PRDATA, 32'h0);
        repeat (30) @(negedge PCLK);

        PRESET = 1'b1;
        apb_write(8'h04, 32'h1);
        PRESET = 1'b0;
        chk("reset_priority", PRDATA, 32'h0);

        apb_write(8'h00, 32'h7);
        chk("frame111_prdata", PRDATA, 32'h1E);
        car_v = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            car_v = {car_v[6:0], ir_led_c};
        end
        chk("carrier_toggle", {27'b0, car_v[7:3] ^ car_v[6:2]}, 32'h1F);
        chk("carrier_guard", {30'b0, car_v[1:0]}, 32'd0);
        wait_idle();
        repeat (3) @(negedge PCLK);

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
